// File: rtl/fetch_pkg.sv
// Shared constants, entry type and sizing helper for the fetch front end.
package fetch_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam int          DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;
    localparam int          PC_STEP_DEF  = 4;

    // Pointer width; clamped to 1 so a degenerate depth still yields a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request path and decode handshake of the fetch stage.
interface fetch_if import fetch_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x W storage, head read combinationally from the array.
module fetch_fifo import fetch_pkg::*; #(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int W     = 2 * XLEN_DEF,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [PW:0]  count,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/fetch_frontend.sv
// Decoupled fetch: PC generator, one-cycle imem request path, prefetch queue to decode.
module fetch_frontend import fetch_pkg::*; #(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    fetch_if.master         bus,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            err_misalign
);
    localparam int              PW         = ptr_w(DEPTH);
    localparam int              OW         = PW + 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(PC_STEP - 1);

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   req_pc_q;
    logic              inflight_q;
    logic [PW:0]       count;
    logic              full;
    logic              empty;
    logic [2*XLEN-1:0] head;
    logic              pop;
    logic [OW-1:0]     occ;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;

    // Credit check counts the in-flight response, so a push never lands on a full queue.
    assign bus.out_valid = rst && !empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign occ           = OW'(count) + OW'(inflight_q) - OW'(pop);
    assign bus.imem_req  = rst && clk_en && !redirect_valid && (occ < OW'(DEPTH));
    assign bus.imem_addr = pc_q;
    assign bus.out_pc    = bus.out_valid ? head[2*XLEN-1:XLEN] : '0;
    assign bus.out_instr = bus.out_valid ? head[XLEN-1:0]      : '0;

    assign fifo_flush = clk_en && (!rst || redirect_valid);
    assign fifo_push  = clk_en && rst && !redirect_valid && inflight_q;
    assign fifo_pop   = clk_en && rst && !redirect_valid && pop;

    fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
        .clk   (clk),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_pc_q, bus.imem_rdata}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (!rst) begin
                pc_q         <= RESET_PC;
                inflight_q   <= 1'b0;
                err_misalign <= 1'b0;
            end else if (redirect_valid) begin
                pc_q       <= redirect_pc & ~ALIGN_MASK;
                inflight_q <= 1'b0;
                if (|(redirect_pc & ALIGN_MASK)) err_misalign <= 1'b1;
            end else begin
                inflight_q <= bus.imem_req;
                if (bus.imem_req) begin
                    req_pc_q <= pc_q;
                    pc_q     <= pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    no_push_when_full: assert property (@(posedge clk) !(fifo_push && full && !fifo_pop));
endmodule

// File: tb/tb_fetch_frontend.sv
// Directed vector table plus randomized traffic against a queue-level fetch model.
module tb_fetch_frontend;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err_misalign;
    logic [31:0] mem_addr;

    fetch_if #(.XLEN(32)) bus ();

    fetch_frontend #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .bus            (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .err_misalign   (err_misalign)
    );

    always #5 clk = ~clk;

    // Memory returns addr + 0x1000 one enabled cycle after the request.
    always @(posedge clk) if (clk_en && bus.imem_req) mem_addr <= bus.imem_addr;
    assign bus.imem_rdata = mem_addr + 32'h1000;

    typedef struct {
        bit          r, e, rdy, rd;
        logic [31:0] rpc;
        bit          ereq;
        logic [31:0] eaddr;
        bit          evld;
        logic [31:0] epc;
        bit          eerr;
    } vec_t;
    vec_t tbl[$];

    fetch_entry_t m_q[$];
    logic [31:0]  m_pc, m_ipc;
    bit           m_infl, m_err, m_req, m_pop, armed;
    int           tests = 0, fails = 0;

    function automatic void add(bit r, bit e, bit rdy, bit rd, logic [31:0] rpc,
                                bit ereq, logic [31:0] eaddr, bit evld, logic [31:0] epc, bit eerr);
        vec_t v;
        v = '{r:r, e:e, rdy:rdy, rd:rd, rpc:rpc, ereq:ereq, eaddr:eaddr, evld:evld, epc:epc, eerr:eerr};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit rdy, input bit rd, input logic [31:0] rpc);
        rst            = r;
        clk_en         = e;
        bus.out_ready  = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    // Model view: queue of {pc, instr} plus at most one outstanding request.
    task automatic model_check();
        bit          v;
        int          occ;
        logic [31:0] epc, ein;
        v     = rst && (m_q.size() > 0);
        epc   = v ? m_q[0].pc    : 32'h0;
        ein   = v ? m_q[0].instr : 32'h0;
        m_pop = v && bus.out_ready;
        occ   = m_q.size() + int'(m_infl) - int'(m_pop);
        m_req = rst && clk_en && !redirect_valid && (occ < DEPTH);
        if (armed) begin
            chk("m_imem_req", 32'(bus.imem_req), 32'(m_req));
            if (m_req) chk("m_imem_addr", bus.imem_addr, m_pc);
            chk("m_out_valid", 32'(bus.out_valid), 32'(v));
            chk("m_out_pc", bus.out_pc, epc);
            chk("m_out_instr", bus.out_instr, ein);
            chk("m_err", 32'(err_misalign), 32'(m_err));
        end
    endtask

    task automatic model_step();
        if (clk_en) begin
            if (!rst) begin
                m_q.delete();
                m_pc   = 32'h0;
                m_infl = 1'b0;
                m_err  = 1'b0;
                armed  = 1'b1;
            end else if (redirect_valid) begin
                m_q.delete();
                m_pc   = redirect_pc & ~32'h3;
                m_infl = 1'b0;
                if ((redirect_pc % 4) != 0) m_err = 1'b1;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_infl) m_q.push_back('{pc: m_ipc, instr: m_ipc + 32'h1000});
                if (m_req) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 32'd4;
                end
                m_infl = m_req;
            end
        end
    endtask

    initial begin
        armed = 1'b0;
        //   r e rdy rd rpc            | req addr          vld pc            err
        add(0,1,1,0,32'h0,             0,32'h0,            0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h0,            0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h4,            0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h8,            1,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'hC,            1,32'h4,          0);
        add(1,1,1,0,32'h0,             1,32'h10,           1,32'h8,          0);
        add(1,1,0,0,32'h0,             1,32'h14,           1,32'hC,          0);
        add(1,1,0,0,32'h0,             1,32'h18,           1,32'hC,          0);
        add(1,1,0,0,32'h0,             0,32'h0,            1,32'hC,          0);
        add(1,1,0,0,32'h0,             0,32'h0,            1,32'hC,          0);
        add(1,1,1,0,32'h0,             1,32'h1C,           1,32'hC,          0);
        add(1,1,1,0,32'h0,             1,32'h20,           1,32'h10,         0);
        add(1,1,0,1,32'h200,           0,32'h0,            1,32'h14,         0);
        add(1,1,1,0,32'h0,             1,32'h200,          0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h204,          0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h208,          1,32'h200,        0);
        add(1,1,1,1,32'h302,           0,32'h0,            1,32'h204,        0);
        add(1,1,1,0,32'h0,             1,32'h300,          0,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'h304,          0,32'h0,          1);
        add(1,1,1,1,32'hFFFF_FFFC,     0,32'h0,            1,32'h300,        1);
        add(1,1,1,0,32'h0,             1,32'hFFFF_FFFC,    0,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'h0,            0,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'h4,            1,32'hFFFF_FFFC,  1);
        add(1,0,1,0,32'h0,             0,32'h0,            1,32'h0,          1);
        add(1,0,1,0,32'h0,             0,32'h0,            1,32'h0,          1);
        add(1,0,1,0,32'h0,             0,32'h0,            1,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'h8,            1,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'hC,            1,32'h4,          1);
        add(0,1,1,0,32'h0,             0,32'h0,            0,32'h0,          1);
        add(1,1,1,0,32'h0,             1,32'h0,            0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h4,            0,32'h0,          0);
        add(1,1,1,0,32'h0,             1,32'h8,            1,32'h0,          0);

        apply(0, 1, 1, 0, 32'h0);
        model_check();
        model_step();
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            model_check();
            chk($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].eaddr);
            chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].evld));
            chk($sformatf("row%0d out_pc", i), bus.out_pc, tbl[i].evld ? tbl[i].epc : 32'h0);
            chk($sformatf("row%0d out_instr", i), bus.out_instr,
                tbl[i].evld ? tbl[i].epc + 32'h1000 : 32'h0);
            chk($sformatf("row%0d err_misalign", i), 32'(err_misalign), 32'(tbl[i].eerr));
            model_step();
            @(posedge clk); #1;
        end

        for (int n = 0; n < 3000; n++) begin
            bit          r, e, rdy, rd;
            logic [31:0] rpc;
            int          rdy_pct;
            rdy_pct = ((n / 200) % 3 == 0) ? 20 : 80;
            r   = ($urandom_range(0, 99) >= 2);
            e   = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            rd  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom & ~32'h3;
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF0;
                default: rpc = 32'($urandom_range(0, 1023)) << 2;
            endcase
            apply(r, e, rdy, rd, rpc);
            model_check();
            model_step();
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
